// File: rtl/input_debounce.sv
// input_debounce: board-input front end. Synchronises and debounces the slide
// switches and push buttons. It produces stable levels, registered rise/fall
// pulses and button press pulses, all paced by a shared sample-tick prescaler.
// Optional build macro AUTOREPEAT_EN adds a per-button hold/auto-repeat FSM.
// Without it, btn_press_o is simply the debounced rising edge.
module input_debounce #(
   parameter int NSW          = 16,
   parameter int NBTN         = 5,
   parameter int TICK_DIV     = 100000,
   parameter int STABLE_CNT   = 8,
   parameter int HOLD_TICKS   = 500,
   parameter int REPEAT_TICKS = 100
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NSW-1:0]  sw_i,
   input  logic [NBTN-1:0] btn_i,
   output logic [NSW-1:0]  sw_o,
   output logic [NSW-1:0]  sw_rise_o,
   output logic [NSW-1:0]  sw_fall_o,
   output logic [NBTN-1:0] btn_o,
   output logic [NBTN-1:0] btn_press_o,
   output logic            tick_o
);

   localparam int NB = NSW + NBTN;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);

   // Reject parameter sets the counters below cannot represent.
   if (TICK_DIV < 2 || STABLE_CNT < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
      $error("input_debounce: invalid parameter set");
   end

   // Buttons sit above the switches in the combined input vector.
   logic [NB-1:0]   sync1_d, sync1_q, sync2_d, sync2_q;
   logic [PW-1:0]   presc_d, presc_q;
   logic            tick;
   logic [NB-1:0]   stable_d, stable_q;
   logic [CW-1:0]   cnt_d [NB];
   logic [CW-1:0]   cnt_q [NB];
   logic [NSW-1:0]  rise_d, rise_q, fall_d, fall_q;
   logic [NBTN-1:0] btn_rise;
   logic [NBTN-1:0] press_d, press_q;

   // Two-flop synchroniser inputs and the free-running sample prescaler.
   always_comb begin
      sync1_d = {btn_i, sw_i};
      sync2_d = sync1_q;
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // Per-bit debounce: any agreeing tick restarts the run of differing ticks.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (tick) begin
         for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
               cnt_d[i]    = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      rise_d   = stable_d[NSW-1:0] & ~stable_q[NSW-1:0];
      fall_d   = ~stable_d[NSW-1:0] & stable_q[NSW-1:0];
      btn_rise = stable_d[NB-1:NSW] & ~stable_q[NB-1:NSW];
   end

`ifdef AUTOREPEAT_EN
   localparam int TMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_TICKS - 1);
   localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_TICKS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} btn_state_e;

   btn_state_e    state_d [NBTN];
   btn_state_e    state_q [NBTN];
   logic [TW-1:0] tcnt_d  [NBTN];
   logic [TW-1:0] tcnt_q  [NBTN];

   // Button hold/repeat FSM; a release forces IDLE ahead of any repeat pulse.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      press_d = '0;
      for (int b = 0; b < NBTN; b++) begin
         if (!stable_d[NSW+b]) begin
            state_d[b] = ST_IDLE;
            tcnt_d[b]  = '0;
         end else begin
            case (state_q[b])
               ST_IDLE: begin
                  if (btn_rise[b]) begin
                     press_d[b] = 1'b1;
                     tcnt_d[b]  = '0;
                     state_d[b] = ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (tick) begin
                     if (tcnt_q[b] == HOLD_LAST) begin
                        press_d[b] = 1'b1;
                        tcnt_d[b]  = '0;
                        state_d[b] = ST_REPEAT;
                     end else begin
                        tcnt_d[b] = tcnt_q[b] + TW'(1);
                     end
                  end
               end
               ST_REPEAT: begin
                  if (tick) begin
                     if (tcnt_q[b] == REPEAT_LAST) begin
                        press_d[b] = 1'b1;
                        tcnt_d[b]  = '0;
                     end else begin
                        tcnt_d[b] = tcnt_q[b] + TW'(1);
                     end
                  end
               end
               default: begin
                  state_d[b] = ST_IDLE;
                  tcnt_d[b]  = '0;
               end
            endcase
         end
      end
   end

   // Button FSM state and tick-count registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int b = 0; b < NBTN; b++) begin
            state_q[b] <= ST_IDLE;
            tcnt_q[b]  <= '0;
         end
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
      end
   end
`else
   // Without auto-repeat a press is just the debounced rising edge.
   always_comb begin
      press_d = btn_rise;
   end
`endif

   // Synchroniser, prescaler, debounce state and registered edge pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         presc_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= '0;
         end
         rise_q   <= '0;
         fall_q   <= '0;
         press_q  <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         presc_q  <= presc_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         press_q  <= press_d;
      end
   end

   assign sw_o        = stable_q[NSW-1:0];
   assign btn_o       = stable_q[NB-1:NSW];
   assign sw_rise_o   = rise_q;
   assign sw_fall_o   = fall_q;
   assign btn_press_o = press_q;
   assign tick_o      = tick;

endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed bench for input_debounce with small sim
// parameters (TICK_DIV=4, STABLE_CNT=3, HOLD_TICKS=5, REPEAT_TICKS=2).
// Honours AUTOREPEAT_EN for the expected number of button press pulses.
module tb_input_debounce;

   logic        clk;
   logic        rstn;
   logic [15:0] sw_i;
   logic [4:0]  btn_i;
   logic [15:0] sw_o, sw_rise_o, sw_fall_o;
   logic [4:0]  btn_o, btn_press_o;
   logic        tick_o;

   int errors;
   int checks;

   int rise_cnt  [16];
   int fall_cnt  [16];
   int press_cnt [5];
   int rise_all;
   int fall_all;

`ifdef AUTOREPEAT_EN
   // accept + repeats at +5,+7,...,+19 ticks inside the 80-clk window
   localparam int EXP_PRESS = 9;
`else
   localparam int EXP_PRESS = 1;
`endif

   typedef struct {
      logic [15:0] sw;
      logic [4:0]  btn;
      int          clks;
      logic [15:0] exp_sw;
      logic [4:0]  exp_btn;
   } vec_t;

   vec_t vecs [6];

   input_debounce #(
      .NSW(16), .NBTN(5), .TICK_DIV(4), .STABLE_CNT(3),
      .HOLD_TICKS(5), .REPEAT_TICKS(2)
   ) dut (
      .clk(clk), .rstn(rstn), .sw_i(sw_i), .btn_i(btn_i),
      .sw_o(sw_o), .sw_rise_o(sw_rise_o), .sw_fall_o(sw_fall_o),
      .btn_o(btn_o), .btn_press_o(btn_press_o), .tick_o(tick_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 16; i++) begin
         rise_cnt[i] += int'(sw_rise_o[i]);
         fall_cnt[i] += int'(sw_fall_o[i]);
      end
      for (int i = 0; i < 5; i++) press_cnt[i] += int'(btn_press_o[i]);
      if (sw_rise_o == 16'hFFFF) rise_all++;
      if (sw_fall_o == 16'hFFFF) fall_all++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 16; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
      end
      for (int i = 0; i < 5; i++) press_cnt[i] = 0;
      rise_all = 0;
      fall_all = 0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {5'd0, sw_o, sw_rise_o, sw_fall_o, btn_o, btn_press_o, tick_o};
   endfunction

   function automatic int sum_fall();
      int s = 0;
      for (int i = 0; i < 16; i++) s += fall_cnt[i];
      return s;
   endfunction

   function automatic int sum_rise();
      int s = 0;
      for (int i = 0; i < 16; i++) s += rise_cnt[i];
      return s;
   endfunction

   initial begin
      int   bad;
      int   nz;
      int   n;
      logic found;
      logic exp_tick;

      errors = 0;
      checks = 0;
      rstn   = 1'b0;
      sw_i   = '0;
      btn_i  = '0;
      clear_counts();

      vecs[0] = '{16'h1234, 5'b00000, 20, 16'h1234, 5'b00000};
      vecs[1] = '{16'hA5A5, 5'b00101, 20, 16'hA5A5, 5'b00101};
      vecs[2] = '{16'h5A5A, 5'b11010, 20, 16'h5A5A, 5'b11010};
      vecs[3] = '{16'h0000, 5'b00000, 20, 16'h0000, 5'b00000};
      vecs[4] = '{16'hFFFF, 5'b11111,  6, 16'h0000, 5'b00000};
      vecs[5] = '{16'hFFFF, 5'b11111, 20, 16'hFFFF, 5'b11111};

      // reset and idle behaviour
      step(3);
      chk("reset_outputs", all_outs(), 64'd0);
      rstn = 1'b1;
      bad = 0;
      nz  = 0;
      for (int k = 1; k <= 100; k++) begin
         step(1);
         exp_tick = ((k % 4) == 3);
         if (tick_o !== exp_tick) bad++;
         if ({sw_o, sw_rise_o, sw_fall_o, btn_o, btn_press_o} !== '0) nz++;
      end
      chk("tick_phase_errors", bad, 0);
      chk("idle_nonzero_cycles", nz, 0);

      // single switch acceptance within 15 clk
      clear_counts();
      sw_i = 16'h0001;
      step(15);
      chk("sw0_accept", sw_o, 16'h0001);
      step(10);
      chk("sw0_rise_count", rise_cnt[0], 1);
      chk("sw0_total_rise", sum_rise(), 1);
      chk("sw0_total_fall", sum_fall(), 0);

      // 2-tick glitch on bit 3 is ignored
      clear_counts();
      sw_i = 16'h0009;
      step(8);
      sw_i = 16'h0001;
      step(24);
      chk("glitch_sw_o", sw_o, 16'h0001);
      chk("glitch_rise3", rise_cnt[3], 0);
      chk("glitch_fall3", fall_cnt[3], 0);

      // table-driven level vectors
      for (int v = 0; v < 6; v++) begin
         sw_i  = vecs[v].sw;
         btn_i = vecs[v].btn;
         step(vecs[v].clks);
         chk($sformatf("vec%0d_sw_o", v), sw_o, vecs[v].exp_sw);
         chk($sformatf("vec%0d_btn_o", v), btn_o, vecs[v].exp_btn);
      end

      // all switches rise together, then fall together
      sw_i  = '0;
      btn_i = '0;
      step(20);
      clear_counts();
      sw_i = 16'hFFFF;
      step(20);
      chk("all_rise_sw_o", sw_o, 16'hFFFF);
      chk("all_rise_cycles", rise_all, 1);
      chk("all_rise_no_fall", sum_fall(), 0);
      sw_i = 16'h0000;
      step(20);
      chk("all_fall_sw_o", sw_o, 16'h0000);
      chk("all_fall_cycles", fall_all, 1);
      chk("all_rise_total", sum_rise(), 16);

      // button hold: one press, plus repeats when enabled
      clear_counts();
      btn_i = 5'b00001;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         step(1);
         if (press_cnt[0] != 0) found = 1'b1;
      end
      chk("btn_press_seen", found, 1'b1);
      chk("btn_press_with_level", {btn_o[0], btn_press_o[0]}, 2'b11);
      step(80);
      chk("btn_press_count", press_cnt[0], EXP_PRESS);
      chk("btn_other_press", press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4], 0);
      btn_i = '0;
      step(20);
      chk("btn_release", btn_o, 5'b00000);

      // async reset mid-debounce, then full re-acceptance
      sw_i  = 16'h0080;
      btn_i = 5'b00010;
      step(2);
      n = 0;
      for (int k = 0; k < 20 && n < 2; k++) begin
         step(1);
         if (tick_o) n++;
      end
      chk("pre_reset_ticks", n, 2);
      step(1);
      chk("pre_reset_not_accepted", sw_o, 16'h0000);
      rstn = 1'b0;
      #1;
      chk("mid_reset_outputs", all_outs(), 64'd0);
      step(1);
      rstn = 1'b1;
      bad = 0;
      for (int k = 1; k <= 11; k++) begin
         step(1);
         if (sw_o !== 16'h0000 || btn_o !== 5'b00000) bad++;
      end
      chk("reaccept_too_early", bad, 0);
      step(1);
      chk("reaccept_sw_o", sw_o, 16'h0080);
      chk("reaccept_rise", sw_rise_o, 16'h0080);
      chk("reaccept_btn_o", btn_o, 5'b00010);
      chk("reaccept_press", btn_press_o, 5'b00010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
